// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider / clock-enable generator.
// Define CLKDIV_SYNC_LOAD_EN to defer divisor loads to each channel's next terminal count.
module clkdiv_multi #(
  parameter int NCH      = 4,
  parameter int CNT_W    = 16,
  parameter int DIV_INIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic             wr_en,
  input  logic [3:0]       wr_ch,
  input  logic [CNT_W-1:0] wr_data,
  output logic             wr_ack,
  output logic             wr_err,
  input  logic [3:0]       rd_ch,
  output logic [CNT_W-1:0] rd_data,
  output logic [NCH-1:0]   div_out,
  output logic [NCH-1:0]   tick
);

  localparam logic [4:0]       NCH_L    = 5'(NCH);
  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DIV_INIT);

  logic [CNT_W-1:0] half_q [NCH];
  logic [CNT_W-1:0] half_d [NCH];
  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] cnt_d  [NCH];
  logic [NCH-1:0]   div_q, div_d;
  logic [NCH-1:0]   tick_q, tick_d;
  logic             wr_ack_q, wr_ack_d;
  logic             wr_err_q, wr_err_d;
`ifdef CLKDIV_SYNC_LOAD_EN
  logic [CNT_W-1:0] pend_q [NCH];
  logic [CNT_W-1:0] pend_d [NCH];
  logic [NCH-1:0]   pend_v_q, pend_v_d;
`endif

  logic wr_ok;
  assign wr_ok    = wr_en && ({1'b0, wr_ch} < NCH_L);
  assign wr_ack_d = wr_ok;
  assign wr_err_d = wr_en && ({1'b0, wr_ch} >= NCH_L);

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path leaves it unassigned and infers a latch.
    half_d = half_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = '0;
`ifdef CLKDIV_SYNC_LOAD_EN
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
`endif
    for (int i = 0; i < NCH; i++) begin
`ifdef CLKDIV_SYNC_LOAD_EN
      if (en[i]) begin
        if (cnt_q[i] == half_q[i]) begin
          cnt_d[i]  = '0;
          div_d[i]  = ~div_q[i];
          tick_d[i] = 1'b1;
          if (pend_v_q[i]) begin
            half_d[i]   = pend_q[i];
            pend_v_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      // Placed after the terminal handling so a write on a terminal edge stays pending.
      if (wr_ok && wr_ch == 4'(i)) begin
        pend_d[i]   = wr_data;
        pend_v_d[i] = 1'b1;
      end
`else
      // An immediate load restarts the half-period and suppresses that edge's toggle.
      if (wr_ok && wr_ch == 4'(i)) begin
        half_d[i] = wr_data;
        cnt_d[i]  = '0;
      end else if (en[i]) begin
        if (cnt_q[i] == half_q[i]) begin
          cnt_d[i]  = '0;
          div_d[i]  = ~div_q[i];
          tick_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
`endif
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_ch == 4'(i)) rd_data = half_q[i];
    end
  end

  // NOTE: these per-channel arrays are architectural state, not RAM, so they are reset like any other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        half_q[i] <= HALF_RST;
        cnt_q[i]  <= '0;
`ifdef CLKDIV_SYNC_LOAD_EN
        pend_q[i] <= '0;
`endif
      end
`ifdef CLKDIV_SYNC_LOAD_EN
      pend_v_q <= '0;
`endif
      div_q    <= '0;
      tick_q   <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples its _d from before this edge.
      half_q   <= half_d;
      cnt_q    <= cnt_d;
`ifdef CLKDIV_SYNC_LOAD_EN
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
`endif
      div_q    <= div_d;
      tick_q   <= tick_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign div_out = div_q;
  assign tick    = tick_q;
  assign wr_ack  = wr_ack_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi; expectations follow CLKDIV_SYNC_LOAD_EN when defined.
module tb_clkdiv_multi;
  localparam int NCH   = 4;
  localparam int CNT_W = 16;
`ifdef CLKDIV_SYNC_LOAD_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   en;
  logic             wr_en;
  logic [3:0]       wr_ch;
  logic [CNT_W-1:0] wr_data;
  logic             wr_ack, wr_err;
  logic [3:0]       rd_ch;
  logic [CNT_W-1:0] rd_data;
  logic [NCH-1:0]   div_out, tick;

  always #5 clk = ~clk;

  clkdiv_multi #(.NCH(NCH), .CNT_W(CNT_W), .DIV_INIT(4)) dut (
    .clk(clk), .reset(reset), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err), .rd_ch(rd_ch),
    .rd_data(rd_data), .div_out(div_out), .tick(tick)
  );

  typedef struct { logic [3:0] ch; logic [15:0] data; logic ack; logic err; } wr_vec_t;
  typedef struct { int ch; int half; } per_vec_t;
  typedef struct { logic [3:0] ch; logic [15:0] exp; } rd_vec_t;

  wr_vec_t  wv [4];
  per_vec_t pv [4];
  rd_vec_t  rv [4];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until div_out[ch] changes; -1 if it never does within maxc.
  task automatic wait_toggle(input int ch, input int maxc, output int n);
    logic prev;
    prev = div_out[ch];
    n = 0;
    do begin
      step();
      n++;
    end while (div_out[ch] === prev && n < maxc);
    if (div_out[ch] === prev) n = -1;
  endtask

  task automatic write(input logic [3:0] ch, input logic [15:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  int n;
  int tcnt [NCH];
  logic d;

  initial begin
    wv[0] = '{ch: 4'd1,  data: 16'd0, ack: 1'b1, err: 1'b0};
    wv[1] = '{ch: 4'd2,  data: 16'd2, ack: 1'b1, err: 1'b0};
    wv[2] = '{ch: 4'd9,  data: 16'd5, ack: 1'b0, err: 1'b1};
    wv[3] = '{ch: 4'd15, data: 16'd1, ack: 1'b0, err: 1'b1};
    pv[0] = '{ch: 0, half: 5};
    pv[1] = '{ch: 1, half: 1};
    pv[2] = '{ch: 2, half: 3};
    pv[3] = '{ch: 3, half: 5};
    rv[0] = '{ch: 4'd9,  exp: 16'd0};
    rv[1] = '{ch: 4'd1,  exp: 16'd0};
    rv[2] = '{ch: 4'd2,  exp: 16'd2};
    rv[3] = '{ch: 4'd15, exp: 16'd0};

    reset = 1'b1; en = '1; wr_en = 1'b0; wr_ch = '0; wr_data = '0; rd_ch = '0;
    step(); step();
    reset = 1'b0;
    check("rst_div", div_out, 4'h0);
    check("rst_tick", tick, 4'h0);
    check("rst_ack_err", {wr_ack, wr_err}, 2'b00);
    for (int i = 0; i < NCH; i++) begin
      rd_ch = 4'(i); #1;
      check($sformatf("rst_half%0d", i), rd_data, 16'd4);
    end

    // First rise lands on the fifth edge after release.
    repeat (4) step();
    check("pre_rise_div", div_out, 4'h0);
    step();
    check("first_rise_div", div_out, 4'hF);
    check("first_rise_tick", tick, 4'hF);
    for (int i = 0; i < NCH; i++) tcnt[i] = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      for (int i = 0; i < NCH; i++) tcnt[i] += int'(tick[i]);
    end
    for (int i = 0; i < NCH; i++) check($sformatf("ticks_per10_ch%0d", i), tcnt[i], 2);

    for (int k = 0; k < 4; k++) begin
      write(wv[k].ch, wv[k].data);
      check($sformatf("wr%0d_ack", k), wr_ack, wv[k].ack);
      check($sformatf("wr%0d_err", k), wr_err, wv[k].err);
      step();
      check($sformatf("wr%0d_pulse_end", k), {wr_ack, wr_err}, 2'b00);
    end
    repeat (12) step();

    for (int k = 0; k < 4; k++) begin
      wait_toggle(pv[k].ch, 40, n);
      wait_toggle(pv[k].ch, 40, n);
      check($sformatf("half_period_ch%0d", pv[k].ch), n, pv[k].half);
      wait_toggle(pv[k].ch, 40, n);
      check($sformatf("half_period2_ch%0d", pv[k].ch), n, pv[k].half);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      check("ch1_tick_stuck", tick[1], 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      rd_ch = rv[k].ch; #1;
      check($sformatf("rd_ch%0d", rv[k].ch), rd_data, rv[k].exp);
    end

    // Stop ch0 for 7 cycles at cnt=2; it must resume with 3 edges left.
    wait_toggle(0, 20, n);
    step(); step();
    d = div_out[0];
    en[0] = 1'b0;
    for (int c = 0; c < 7; c++) begin
      step();
      check("stop_div_hold", div_out[0], d);
      check("stop_tick_low", tick[0], 1'b0);
    end
    en[0] = 1'b1;
    wait_toggle(0, 20, n);
    check("resume_remaining", n, 3);
    wait_toggle(0, 20, n);
    check("resume_period", n, 5);

    // H=7 written to ch0 at cnt=2.
    step(); step();
    d = div_out[0];
    write(0, 16'd7);
    check("ld7_ack", wr_ack, 1'b1);
    check("ld7_div_hold", div_out[0], d);
    check("ld7_tick", tick[0], 1'b0);
    rd_ch = 4'd0; #1;
    check("ld7_rd", rd_data, SYNC ? 16'd4 : 16'd7);
    wait_toggle(0, 40, n);
    check("ld7_first", n, SYNC ? 2 : 8);
    wait_toggle(0, 40, n);
    check("ld7_period_a", n, 8);
    wait_toggle(0, 40, n);
    check("ld7_period_b", n, 8);
    check("ld7_rd_after", rd_data, 16'd7);

    // Write H=5 to ch2 exactly on its terminal edge (cnt==half==2).
    wait_toggle(2, 20, n);
    step(); step();
    d = div_out[2];
    write(2, 16'd5);
    check("term_wr_div", div_out[2], SYNC ? ~d : d);
    check("term_wr_tick", tick[2], SYNC ? 1'b1 : 1'b0);
    wait_toggle(2, 40, n);
    check("term_wr_first", n, SYNC ? 3 : 6);
    wait_toggle(2, 40, n);
    check("term_wr_period", n, 6);

    // Back-to-back writes to ch3: only the last one sticks.
    write(3, 16'd3);
    write(3, 16'd7);
    wait_toggle(3, 40, n);
    wait_toggle(3, 40, n);
    check("b2b_period_a", n, 8);
    wait_toggle(3, 40, n);
    check("b2b_period_b", n, 8);
    rd_ch = 4'd3; #1;
    check("b2b_rd", rd_data, 16'd7);

    // Reset with a pending ch0 load and a simultaneous ch1 write.
    wait_toggle(0, 40, n);
    write(0, 16'd2);
    reset = 1'b1; wr_en = 1'b1; wr_ch = 4'd1; wr_data = 16'd9;
    step();
    reset = 1'b0; wr_en = 1'b0;
    check("mid_rst_div", div_out, 4'h0);
    check("mid_rst_tick", tick, 4'h0);
    check("mid_rst_ack_err", {wr_ack, wr_err}, 2'b00);
    rd_ch = 4'd1; #1;
    check("mid_rst_rd1", rd_data, 16'd4);
    rd_ch = 4'd0; #1;
    check("mid_rst_rd0", rd_data, 16'd4);
    wait_toggle(0, 40, n);
    check("mid_rst_first", n, 5);
    check("mid_rst_all_rise", div_out, 4'hF);
    wait_toggle(0, 40, n);
    check("mid_rst_period", n, 5);
    check("mid_rst_rd0_after", rd_data, 16'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
